// File: rtl/mips_pkg.sv
// Shared encodings for the multicycle MIPS control path: FSM states,
// opcode/funct codes, datapath mux selects and the control word.
package mips_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTE  = 4'd6,
    S_ALUWB    = 4'd7,
    S_BRANCH   = 4'd8,
    S_ADDIEX   = 4'd9,
    S_ADDIWB   = 4'd10,
    S_JUMP     = 4'd11,
    S_ILLEGAL  = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_REG   = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef struct packed {
    logic       iord;
    logic       alusrca;
    logic       irwrite;
    logic       pcwrite;
    logic       memwrite;
    logic       regdst;
    logic       memtoreg;
    logic       regwrite;
    logic       branch;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic [1:0] aluop;
    logic       instr_done;
  } ctrl_t;

  function automatic logic funct_ok(input logic [5:0] funct);
    return (funct == FN_ADD) || (funct == FN_SUB) || (funct == FN_AND) ||
           (funct == FN_OR)  || (funct == FN_SLT);
  endfunction

endpackage

// File: rtl/controlunit_outdec.sv
// Combinational map from FSM state to datapath control word. mem_ready only
// qualifies the FETCH write enables and the MEMWRITE completion pulse.
module controlunit_outdec
  import mips_pkg::*;
(
  input  state_t state,
  input  logic   mem_ready,
  output ctrl_t  ctrl
);

  always_comb begin
    ctrl = '0;
    unique case (state)
      S_FETCH: begin
        ctrl.alusrcb = SRCB_FOUR;
        ctrl.irwrite = mem_ready;
        ctrl.pcwrite = mem_ready;
      end
      S_DECODE:  ctrl.alusrcb = SRCB_IMMSH;
      S_MEMADR: begin
        ctrl.alusrca = 1'b1;
        ctrl.alusrcb = SRCB_IMM;
      end
      S_MEMREAD: ctrl.iord = 1'b1;
      S_MEMWB: begin
        ctrl.memtoreg   = 1'b1;
        ctrl.regwrite   = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      S_MEMWRITE: begin
        ctrl.iord       = 1'b1;
        ctrl.memwrite   = 1'b1;
        ctrl.instr_done = mem_ready;
      end
      S_EXECUTE: begin
        ctrl.alusrca = 1'b1;
        ctrl.aluop   = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        ctrl.regdst     = 1'b1;
        ctrl.regwrite   = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      S_BRANCH: begin
        ctrl.alusrca    = 1'b1;
        ctrl.aluop      = ALUOP_SUB;
        ctrl.pcsrc      = PCSRC_ALUOUT;
        ctrl.branch     = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      S_ADDIEX: begin
        ctrl.alusrca = 1'b1;
        ctrl.alusrcb = SRCB_IMM;
      end
      S_ADDIWB: begin
        ctrl.regwrite   = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      S_JUMP: begin
        ctrl.pcsrc      = PCSRC_JUMP;
        ctrl.pcwrite    = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/controlunit.sv
// Multicycle MIPS control FSM with memory wait handshake and sticky
// illegal-instruction flag.
module controlunit
  import mips_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] OP,
  input  logic [5:0] Funct,
  input  logic       MemReady,
  output logic       IorD,
  output logic       ALUSrcA,
  output logic       IRWrite,
  output logic       PCWrite,
  output logic       MemWrite,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic       RegWrite,
  output logic       Branch,
  output logic [1:0] ALUSrcB,
  output logic [1:0] PCSrc,
  output logic [1:0] ALUOp,
  output logic       InstrDone,
  output logic       Illegal
);

  state_t state, next_state, dec_state;
  logic   illegal_q;
  ctrl_t  ctrl;

  always_comb begin
    next_state = state;
    unique case (state)
      S_FETCH:    next_state = MemReady ? S_DECODE : S_FETCH;
      S_DECODE: begin
        unique case (OP)
          OP_LW, OP_SW: next_state = S_MEMADR;
          OP_RTYPE:     next_state = funct_ok(Funct) ? S_EXECUTE : S_ILLEGAL;
          OP_BEQ:       next_state = S_BRANCH;
          OP_ADDI:      next_state = S_ADDIEX;
          OP_J:         next_state = S_JUMP;
          default:      next_state = S_ILLEGAL;
        endcase
      end
      S_MEMADR:   next_state = (OP == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  next_state = MemReady ? S_MEMWB : S_MEMREAD;
      S_MEMWRITE: next_state = MemReady ? S_FETCH : S_MEMWRITE;
      S_EXECUTE:  next_state = S_ALUWB;
      S_ADDIEX:   next_state = S_ADDIWB;
      S_ILLEGAL:  next_state = S_ILLEGAL;
      S_MEMWB, S_ALUWB, S_BRANCH, S_ADDIWB, S_JUMP: next_state = S_FETCH;
      default:    next_state = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_FETCH;
      illegal_q <= 1'b0;
    end else begin
      state <= next_state;
      if (next_state == S_ILLEGAL) illegal_q <= 1'b1;
    end
  end

  // During reset, decode as FETCH with MemReady masked: selects keep their
  // FETCH values and every write enable / done pulse is held low.
  assign dec_state = reset ? S_FETCH : state;

  controlunit_outdec u_outdec (
    .state     (dec_state),
    .mem_ready (MemReady & ~reset),
    .ctrl      (ctrl)
  );

  assign IorD      = ctrl.iord;
  assign ALUSrcA   = ctrl.alusrca;
  assign IRWrite   = ctrl.irwrite;
  assign PCWrite   = ctrl.pcwrite;
  assign MemWrite  = ctrl.memwrite;
  assign RegDst    = ctrl.regdst;
  assign MemtoReg  = ctrl.memtoreg;
  assign RegWrite  = ctrl.regwrite;
  assign Branch    = ctrl.branch;
  assign ALUSrcB   = ctrl.alusrcb;
  assign PCSrc     = ctrl.pcsrc;
  assign ALUOp     = ctrl.aluop;
  assign InstrDone = ctrl.instr_done;
  assign Illegal   = illegal_q;

endmodule

// File: tb/tb_controlunit.sv
// Directed bench for controlunit: walks each instruction class cycle by cycle
// and compares the full output word against hand-derived constants.
module tb_controlunit;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] OP = 6'b0;
  logic [5:0] Funct = 6'b0;
  logic       MemReady = 1'b1;
  logic IorD, ALUSrcA, IRWrite, PCWrite, MemWrite, RegDst, MemtoReg, RegWrite, Branch;
  logic [1:0] ALUSrcB, PCSrc, ALUOp;
  logic InstrDone, Illegal;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  controlunit dut (
    .clk(clk), .reset(reset), .OP(OP), .Funct(Funct), .MemReady(MemReady),
    .IorD(IorD), .ALUSrcA(ALUSrcA), .IRWrite(IRWrite), .PCWrite(PCWrite),
    .MemWrite(MemWrite), .RegDst(RegDst), .MemtoReg(MemtoReg),
    .RegWrite(RegWrite), .Branch(Branch), .ALUSrcB(ALUSrcB), .PCSrc(PCSrc),
    .ALUOp(ALUOp), .InstrDone(InstrDone), .Illegal(Illegal)
  );

  // {IorD,ALUSrcA,IRWrite,PCWrite,MemWrite,RegDst,MemtoReg,RegWrite,Branch}
  //   _ALUSrcB_PCSrc_ALUOp_InstrDone_Illegal
  logic [16:0] obs;
  assign obs = {IorD, ALUSrcA, IRWrite, PCWrite, MemWrite, RegDst, MemtoReg,
                RegWrite, Branch, ALUSrcB, PCSrc, ALUOp, InstrDone, Illegal};

  localparam logic [16:0] E_FETCH   = 17'b001100000_01_00_00_0_0;
  localparam logic [16:0] E_FWAIT   = 17'b000000000_01_00_00_0_0;
  localparam logic [16:0] E_DECODE  = 17'b000000000_11_00_00_0_0;
  localparam logic [16:0] E_MEMADR  = 17'b010000000_10_00_00_0_0;
  localparam logic [16:0] E_MEMREAD = 17'b100000000_00_00_00_0_0;
  localparam logic [16:0] E_MEMWB   = 17'b000000110_00_00_00_1_0;
  localparam logic [16:0] E_MWWAIT  = 17'b100010000_00_00_00_0_0;
  localparam logic [16:0] E_MWDONE  = 17'b100010000_00_00_00_1_0;
  localparam logic [16:0] E_EXEC    = 17'b010000000_00_00_10_0_0;
  localparam logic [16:0] E_ALUWB   = 17'b000001010_00_00_00_1_0;
  localparam logic [16:0] E_BRANCH  = 17'b010000001_00_01_01_1_0;
  localparam logic [16:0] E_ADDIEX  = 17'b010000000_10_00_00_0_0;
  localparam logic [16:0] E_ADDIWB  = 17'b000000010_00_00_00_1_0;
  localparam logic [16:0] E_JUMP    = 17'b000100000_00_10_00_1_0;
  localparam logic [16:0] E_ILL     = 17'b000000000_00_00_00_0_1;

  // Advance to the sample point 2 time units after the next rising edge.
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic test_reset();
    reset = 1'b1; MemReady = 1'b1;
    for (int i = 0; i < 2; i++) begin
      cyc();
      total++;
      if (obs !== E_FWAIT) begin
        bad++; $display("FAIL reset[%0d]: got %b want %b", i, obs, E_FWAIT);
      end
    end
    reset = 1'b0; #1;
    total++;
    if (obs !== E_FETCH) begin
      bad++; $display("FAIL reset_release: got %b want %b", obs, E_FETCH);
    end
  endtask

  task automatic test_fetch_wait();
    MemReady = 1'b0; #1;
    for (int i = 0; i < 2; i++) begin
      total++;
      if (obs !== E_FWAIT) begin
        bad++; $display("FAIL fetch_wait[%0d]: got %b want %b", i, obs, E_FWAIT);
      end
      cyc();
    end
    MemReady = 1'b1; #1;
    total++;
    if (obs !== E_FETCH) begin
      bad++; $display("FAIL fetch_ready: got %b want %b", obs, E_FETCH);
    end
  endtask

  task automatic test_lw();
    logic [16:0] seq [5] = '{E_FETCH, E_DECODE, E_MEMADR, E_MEMREAD, E_MEMWB};
    OP = 6'b100011; Funct = 6'b0; MemReady = 1'b1; #1;
    for (int i = 0; i < 5; i++) begin
      total++;
      if (obs !== seq[i]) begin
        bad++; $display("FAIL lw[%0d]: got %b want %b", i, obs, seq[i]);
      end
      cyc();
    end
  endtask

  task automatic test_sw_wait();
    logic [16:0] seq [3] = '{E_FETCH, E_DECODE, E_MEMADR};
    OP = 6'b101011; MemReady = 1'b1; #1;
    for (int i = 0; i < 3; i++) begin
      total++;
      if (obs !== seq[i]) begin
        bad++; $display("FAIL sw[%0d]: got %b want %b", i, obs, seq[i]);
      end
      cyc();
    end
    MemReady = 1'b0; #1;
    for (int i = 0; i < 3; i++) begin
      total++;
      if (obs !== E_MWWAIT) begin
        bad++; $display("FAIL sw_wait[%0d]: got %b want %b", i, obs, E_MWWAIT);
      end
      cyc();
    end
    MemReady = 1'b1; #1;
    total++;
    if (obs !== E_MWDONE) begin
      bad++; $display("FAIL sw_done: got %b want %b", obs, E_MWDONE);
    end
    cyc();
  endtask

  task automatic test_rtype_beq();
    logic [16:0] rseq [4] = '{E_FETCH, E_DECODE, E_EXEC, E_ALUWB};
    logic [16:0] bseq [3] = '{E_FETCH, E_DECODE, E_BRANCH};
    logic [5:0]  fn [5] = '{6'b100010, 6'b100000, 6'b100100, 6'b100101, 6'b101010};
    MemReady = 1'b1;
    for (int f = 0; f < 5; f++) begin
      OP = 6'b000000; Funct = fn[f]; #1;
      for (int i = 0; i < 4; i++) begin
        total++;
        if (obs !== rseq[i]) begin
          bad++; $display("FAIL rtype[f=%b,%0d]: got %b want %b", fn[f], i, obs, rseq[i]);
        end
        cyc();
      end
    end
    OP = 6'b000100; Funct = 6'b0; #1;
    for (int i = 0; i < 3; i++) begin
      total++;
      if (obs !== bseq[i]) begin
        bad++; $display("FAIL beq[%0d]: got %b want %b", i, obs, bseq[i]);
      end
      cyc();
    end
  endtask

  task automatic test_j_addi();
    logic [16:0] jseq [3] = '{E_FETCH, E_DECODE, E_JUMP};
    logic [16:0] aseq [4] = '{E_FETCH, E_DECODE, E_ADDIEX, E_ADDIWB};
    MemReady = 1'b1; OP = 6'b000010; #1;
    for (int i = 0; i < 3; i++) begin
      total++;
      if (obs !== jseq[i]) begin
        bad++; $display("FAIL j[%0d]: got %b want %b", i, obs, jseq[i]);
      end
      cyc();
    end
    OP = 6'b001000; #1;
    for (int i = 0; i < 4; i++) begin
      total++;
      if (obs !== aseq[i]) begin
        bad++; $display("FAIL addi[%0d]: got %b want %b", i, obs, aseq[i]);
      end
      cyc();
    end
  endtask

  // lw with one MemReady=0 cycle in MEMREAD, then reset lands in MEMWB.
  task automatic test_abort();
    logic [16:0] seq [4] = '{E_FETCH, E_DECODE, E_MEMADR, E_MEMREAD};
    OP = 6'b100011; MemReady = 1'b1; #1;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) begin MemReady = 1'b0; #1; end
      total++;
      if (obs !== seq[i]) begin
        bad++; $display("FAIL abort_seq[%0d]: got %b want %b", i, obs, seq[i]);
      end
      cyc();
    end
    total++;
    if (obs !== E_MEMREAD) begin
      bad++; $display("FAIL memread_wait: got %b want %b", obs, E_MEMREAD);
    end
    MemReady = 1'b1;
    cyc();
    reset = 1'b1; #1;
    total++;
    if (obs !== E_FWAIT) begin
      bad++; $display("FAIL abort_in_memwb: got %b want %b", obs, E_FWAIT);
    end
    cyc();
    reset = 1'b0; #1;
    total++;
    if (obs !== E_FETCH) begin
      bad++; $display("FAIL abort_restart: got %b want %b", obs, E_FETCH);
    end
  endtask

  task automatic test_illegal(input logic [5:0] op, input logic [5:0] fn);
    OP = op; Funct = fn; MemReady = 1'b1; #1;
    total++;
    if (obs !== E_FETCH) begin
      bad++; $display("FAIL ill_fetch[%b/%b]: got %b want %b", op, fn, obs, E_FETCH);
    end
    cyc();
    total++;
    if (obs !== E_DECODE) begin
      bad++; $display("FAIL ill_decode[%b/%b]: got %b want %b", op, fn, obs, E_DECODE);
    end
    cyc();
    OP = 6'b100011; Funct = 6'b100000;
    for (int i = 0; i < 20; i++) begin
      total++;
      if (obs !== E_ILL) begin
        bad++; $display("FAIL ill_hold[%b/%b,%0d]: got %b want %b", op, fn, i, obs, E_ILL);
      end
      cyc();
    end
    reset = 1'b1;
    cyc();
    total++;
    if (obs !== E_FWAIT) begin
      bad++; $display("FAIL ill_reset[%b/%b]: got %b want %b", op, fn, obs, E_FWAIT);
    end
    reset = 1'b0; #1;
    total++;
    if (obs !== E_FETCH) begin
      bad++; $display("FAIL ill_restart[%b/%b]: got %b want %b", op, fn, obs, E_FETCH);
    end
  endtask

  initial begin
    test_reset();
    test_fetch_wait();
    test_lw();
    test_sw_wait();
    test_rtype_beq();
    test_j_addi();
    test_abort();
    test_illegal(6'b111111, 6'b000000);
    test_illegal(6'b000000, 6'b000111);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
